prim_clock_gate_ctrl: RTL and testbench
=======================================

Name: prim_clock_gate_ctrl

Overview:
- Parametrised, multi-channel successor to the single-cell clock gate. Each channel has an idle-timeout clock-enable controller with a wake handshake.
- Outputs are clock *enables*, not gated clocks. They drive per-domain enable pins, or a prim_clock_gating instance where gating is enabled.
- Each channel gates its domain off after a programmable idle interval and wakes on request. A requester is acknowledged only after a settle delay.
- Sits between subsystem activity/request signals and the clock-enable inputs of peripheral domains.

Parameters:
- NumCh, 4: number of independent channels (>=1).
- IdleCycles, 16: consecutive idle cycles before a channel gates off (>=1).
- WakeCycles, 2: settle cycles between re-enable and acknowledge (>=1).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset. Synchronous, active-high.
- test_en_i  input  1  DFT override; forces every en_o to 1.
- busy_i  input  NumCh  per-channel domain activity; holds the clock on.
- req_i  input  NumCh  per-channel wake/keep-on request; level, held until ack_o.
- force_on_i  input  NumCh  software pin-on; treated as permanent activity.
- en_o  output  NumCh  clock enable per channel.
- ack_o  output  NumCh  request acknowledge: clock enabled and settled.
- gated_o  output  NumCh  status: channel currently in OFF.

Behaviour:
- Per channel, fully independent: a 3-state FSM {ON, OFF, WAKE} plus two counters.
  - idle_cnt: width max($clog2(IdleCycles),1).
  - wake_cnt: width max($clog2(WakeCycles),1).
- act[c] = busy_i[c] | req_i[c] | force_on_i[c].
- Reset (rst_i=1 at a clock edge, including mid-operation, any state):
  - all FSMs go to ON, counters to 0;
  - en_o=all 1s, gated_o=0, ack_o follows req_i (state ON).
- ON:
  - en_o=1.
  - act=1: idle_cnt <= 0.
  - act=0 and idle_cnt<IdleCycles-1: idle_cnt increments.
  - act=0 and idle_cnt==IdleCycles-1: next state OFF, idle_cnt <= 0. Result: IdleCycles consecutive idle cycles, then en_o is low from the following cycle.
  - Any single active cycle restarts the count.
- OFF:
  - en_o=0 (unless test_en_i), gated_o=1.
  - act=1: next state WAKE, wake_cnt <= 0. en_o rises on the cycle after act is seen.
- WAKE:
  - en_o=1, gated_o=0, ack_o=0.
  - wake_cnt increments each cycle. When wake_cnt==WakeCycles-1, next state ON.
  - WAKE lasts exactly WakeCycles cycles and is not aborted if act drops.
  - On entering ON, idle_cnt=0 and normal idle counting applies.
- ack_o[c] = req_i[c] & (state==ON). Combinational from registered state and the input.
  - Wake latency for req_i sampled in OFF at cycle t: en_o=1 at t+1, ack_o=1 at t+1+WakeCycles.
  - Requester holds req_i until ack_o=1, then may drop it. Dropping req_i early is legal: no ack is produced, and the channel still completes WAKE.
- test_en_i=1:
  - en_o forced to all 1s combinationally.
  - FSMs, counters and gated_o keep running normally, so the test mode does not disturb state.
  - ack_o is unaffected (still needs ON).
- Simultaneous events:
  - act=1 in the same cycle idle_cnt hits IdleCycles-1: act wins, stay ON, idle_cnt <= 0.
  - rst_i overrides every transition.
- No combinational path from busy_i/force_on_i to en_o.
- Only combinational input-to-output paths: test_en_i->en_o and req_i->ack_o.

Test Plan (NumCh=4, IdleCycles=16, WakeCycles=2):
- Reset, all inputs 0: en_o=4'hF after reset. Channel 0 keeps en_o=1 for 16 idle cycles; en_o[0]=0 and gated_o[0]=1 from cycle 17. All channels gate together.
- Channel 1 idle for 15 cycles, busy_i[1] pulse on cycle 16 (count-hit cycle), then idle: en_o[1] stays 1. Gates off only after 16 further idle cycles.
- Channel 2 in OFF, req_i[2] raised at cycle t and held:
  - en_o[2]=1 at t+1, ack_o[2]=0 at t+1 and t+2, ack_o[2]=1 at t+3;
  - drop req at t+4 -> OFF again at t+4+16.
- Channel 3 in OFF, req_i[3] pulsed for one cycle: WAKE for 2 cycles, then ON, no ack_o; re-gates 16 idle cycles later. Other channels unaffected throughout.
- All channels OFF:
  - test_en_i=1 -> en_o=4'hF same cycle, gated_o stays 4'hF;
  - test_en_i=0 -> en_o=0 again.
- Channel 0 in WAKE (wake_cnt=1), rst_i=1 for one cycle -> ON, en_o[0]=1, idle_cnt=0. force_on_i[0]=1 held for 100 cycles -> never gates.

Source files
------------

// File: rtl/prim_clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// prim_clock_gate_ctrl: per-channel idle-timeout clock-enable controller with wake handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prim_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] force_on_i,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] gated_o
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              act;

    assign act = busy_i[c] | req_i[c] | force_on_i[c];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_ON;
        idle_q  <= '0;
        wake_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
      end
    end

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
        ST_ON: begin
          // Activity on the count-hit cycle wins and restarts the interval.
          if (act) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            state_d = ST_OFF;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
        ST_OFF: begin
          if (act) begin
            wake_d  = '0;
            state_d = ST_WAKE;
          end
        end
        ST_WAKE: begin
          // Settle period always runs to completion, even if act drops.
          if (wake_q == WAKE_LAST) begin
            wake_d  = '0;
            idle_d  = '0;
            state_d = ST_ON;
          end else begin
            wake_d = wake_q + WAKE_W'(1);
          end
        end
        default: begin
          state_d = ST_ON;
          idle_d  = '0;
          wake_d  = '0;
        end
      endcase
    end

    assign en_o[c]    = test_en_i | (state_q != ST_OFF);
    assign gated_o[c] = (state_q == ST_OFF);
    assign ack_o[c]   = req_i[c] & (state_q == ST_ON);
  end

endmodule

`default_nettype wire

// File: tb/tb_prim_clock_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prim_clock_gate_ctrl: directed scoreboard bench for prim_clock_gate_ctrl (4 ch, idle 16, wake 2)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prim_clock_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       test_en;
  logic [3:0] busy, req, force_on;
  logic [3:0] en, ack, gated;

  typedef struct {
    logic [11:0] exp;
    logic        chk;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_cmp;
  int    n_err;

  prim_clock_gate_ctrl #(
    .NUM_CH     (4),
    .IDLE_CYCLES(16),
    .WAKE_CYCLES(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .test_en_i (test_en),
    .busy_i    (busy),
    .req_i     (req),
    .force_on_i(force_on),
    .en_o      (en),
    .ack_o     (ack),
    .gated_o   (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      if (it.chk) begin
        n_cmp++;
        if ({en, ack, gated} !== it.exp) begin
          n_err++;
          $display("FAIL %s: got en=%b ack=%b gated=%b, expected en=%b ack=%b gated=%b",
                   it.tag, en, ack, gated, it.exp[11:8], it.exp[7:4], it.exp[3:0]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic te, input logic [3:0] b, input logic [3:0] q,
                      input logic [3:0] f, input logic [3:0] e_en, input logic [3:0] e_ack,
                      input logic [3:0] e_gt, input logic chk, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    rst      = r;
    test_en  = te;
    busy     = b;
    req      = q;
    force_on = f;
    it.exp   = {e_en, e_ack, e_gt};
    it.chk   = chk;
    it.tag   = tag;
    sb.push_back(it);
  endtask

  task automatic idle(input int n, input logic [3:0] e_en, input logic [3:0] e_gt, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, e_en, 4'h0, e_gt, 1, tag);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; test_en = 1'b0; busy = '0; req = '0; force_on = '0;

    // Reset, then 16 idle cycles with enables on, then everything gated.
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "rst");
    idle(16, 4'hF, 4'h0, "s1_on");
    idle(2, 4'h0, 4'hF, "s1_off");

    // Channel 1 busy exactly on the count-hit cycle.
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "rst");
    idle(15, 4'hF, 4'h0, "s2_pre");
    step(0, 0, 4'b0010, 0, 0, 4'hF, 4'h0, 4'h0, 1, "s2_hit");
    idle(16, 4'b0010, 4'b1101, "s2_hold");
    idle(1, 4'h0, 4'hF, "s2_off");

    // Channel 2 wake via held request.
    step(0, 0, 0, 4'b0100, 0, 4'h0, 4'h0, 4'hF, 1, "s3_req_t");
    step(0, 0, 0, 4'b0100, 0, 4'b0100, 4'h0, 4'b1011, 1, "s3_t1");
    step(0, 0, 0, 4'b0100, 0, 4'b0100, 4'h0, 4'b1011, 1, "s3_t2");
    step(0, 0, 0, 4'b0100, 0, 4'b0100, 4'b0100, 4'b1011, 1, "s3_ack");
    idle(16, 4'b0100, 4'b1011, "s3_idle");
    idle(1, 4'h0, 4'hF, "s3_regate");

    // Channel 3 single-cycle request: full wake, no ack.
    step(0, 0, 0, 4'b1000, 0, 4'h0, 4'h0, 4'hF, 1, "s4_pulse");
    idle(2, 4'b1000, 4'b0111, "s4_wake");
    idle(16, 4'b1000, 4'b0111, "s4_on");
    idle(1, 4'h0, 4'hF, "s4_regate");

    // Test override while all gated.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 4'hF, 4'h0, 4'hF, 1, "s5_test");
    idle(1, 4'h0, 4'hF, "s5_off");

    // Reset during WAKE (wake_cnt=1), then channel 0 pinned on.
    step(0, 0, 0, 4'b0001, 0, 4'h0, 4'h0, 4'hF, 1, "s6_req");
    idle(1, 4'b0001, 4'b1110, "s6_wake0");
    step(1, 0, 0, 0, 0, 4'b0001, 4'h0, 4'b1110, 1, "s6_wake1_rst");
    for (int i = 1; i <= 100; i++) begin
      if (i <= 16) step(0, 0, 0, 0, 4'b0001, 4'hF, 4'h0, 4'h0, 1, "s6_force_all_on");
      else         step(0, 0, 0, 0, 4'b0001, 4'b0001, 4'h0, 4'b1110, 1, "s6_force");
    end
    step(0, 0, 0, 4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b1110, 1, "s6_ack");
    step(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "tail");

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
